// File: rtl/uram_event_buffer_sched_pkg.sv
// uram_sched_pkg: shared state types and default geometry for the event buffer scheduler
package uram_sched_pkg;
  localparam int DEF_NBUF_BITS = 3;
  localparam int DEF_ADDR_BITS = 7;
  localparam int EVENT_CYCLES = 4 << DEF_ADDR_BITS;
  typedef enum logic [1:0] {W_IDLE, W_ARM, W_WRITE} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_FLUSH} rstate_e;
endpackage

// File: rtl/uram_event_buffer_sched_if.sv
// uram_event_buffer_sched_if: phase/trigger/read-enable inputs and buffer-control outputs of the scheduler
interface uram_event_buffer_sched_if import uram_sched_pkg::*; #(
  parameter int NBUF_BITS = DEF_NBUF_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DROP_CNT_BITS = 16
);
  logic memclk_phase_i;
  logic trig_i;
  logic rd_ce_i;
  logic [NBUF_BITS-1:0] write_buffer_o;
  logic [ADDR_BITS-1:0] write_addr_o;
  logic writing_o;
  logic dat_readout_o;
  logic [NBUF_BITS-1:0] read_buffer_o;
  logic [ADDR_BITS-1:0] read_addr_o;
  logic rd_last_o;
  logic [NBUF_BITS:0] occupancy_o;
  logic full_o;
  logic [DROP_CNT_BITS-1:0] drop_count_o;
  modport master (
    output memclk_phase_i, trig_i, rd_ce_i,
    input write_buffer_o, write_addr_o, writing_o, dat_readout_o, read_buffer_o,
    input read_addr_o, rd_last_o, occupancy_o, full_o, drop_count_o
  );
  modport slave (
    input memclk_phase_i, trig_i, rd_ce_i,
    output write_buffer_o, write_addr_o, writing_o, dat_readout_o, read_buffer_o,
    output read_addr_o, rd_last_o, occupancy_o, full_o, drop_count_o
  );
endinterface

// File: rtl/uram_event_buffer_sched_ring.sv
// uram_sched_ring: FIFO ring pointers and occupancy of committed, not-yet-freed buffers
module uram_sched_ring import uram_sched_pkg::*; #(
  parameter int NBUF_BITS = DEF_NBUF_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_commit,
  input  logic                 i_free,
  output logic [NBUF_BITS-1:0] o_wr_ptr,
  output logic [NBUF_BITS-1:0] o_rd_ptr,
  output logic [NBUF_BITS:0]   o_occupancy,
  output logic                 o_full,
  output logic                 o_empty
);
  logic [NBUF_BITS-1:0] r_wr_ptr, r_rd_ptr;
  logic [NBUF_BITS:0] r_occ;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + NBUF_BITS'(i_commit);
      r_rd_ptr <= r_rd_ptr + NBUF_BITS'(i_free);
      r_occ <= r_occ + (NBUF_BITS+1)'(i_commit) - (NBUF_BITS+1)'(i_free);
    end
  end
  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_occupancy = r_occ;
  assign o_full = r_occ == (NBUF_BITS+1)'(1 << NBUF_BITS);
  assign o_empty = r_occ == '0;
  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_free && o_empty));
  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_commit && o_full && !i_free));
endmodule

// File: rtl/uram_event_buffer_sched.sv
// uram_event_buffer_sched: allocates, writes, queues and throttles readout of event buffers in phase with memclk
module uram_event_buffer_sched import uram_sched_pkg::*; #(
  parameter int NBUF_BITS = DEF_NBUF_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int RD_LATENCY = 4,
  parameter int DROP_CNT_BITS = 16
) (
  input logic memclk_i,
  input logic memclk_rstn_i,
  uram_event_buffer_sched_if.slave bus
);
  localparam int FCW = $clog2(RD_LATENCY + 1);
  wstate_e r_wstate, w_wnext;
  rstate_e r_rstate, w_rnext;
  logic [NBUF_BITS-1:0] w_wr_ptr, w_rd_ptr, r_rbuf;
  logic [NBUF_BITS:0] w_occ;
  logic [ADDR_BITS-1:0] r_waddr, r_raddr;
  logic [DROP_CNT_BITS-1:0] r_drop;
  logic [FCW-1:0] r_fcnt;
  logic r_writing, r_dat, r_rd_last;
  logic w_full, w_empty, w_commit, w_free, w_drop, w_accept, w_rd_hold;
  uram_sched_ring #(.NBUF_BITS(NBUF_BITS)) u_ring (
    .i_clk(memclk_i), .i_rst_n(memclk_rstn_i), .i_commit(w_commit), .i_free(w_free),
    .o_wr_ptr(w_wr_ptr), .o_rd_ptr(w_rd_ptr), .o_occupancy(w_occ), .o_full(w_full), .o_empty(w_empty)
  );
  assign w_rd_hold = (r_rstate != R_IDLE) && (r_rbuf == w_wr_ptr);
  always_comb begin
    w_accept = (r_wstate == W_IDLE) && bus.trig_i && !w_full && !w_rd_hold;
    w_drop = bus.trig_i && !w_accept;
    w_commit = (r_wstate == W_WRITE) && bus.memclk_phase_i && (&r_waddr);
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  w_wnext = w_accept ? W_ARM : W_IDLE;
      W_ARM:   w_wnext = bus.memclk_phase_i ? W_WRITE : W_ARM;
      default: w_wnext = w_commit ? W_IDLE : W_WRITE;
    endcase
  end
  always_comb begin
    w_free = (r_rstate == R_FLUSH) && (r_fcnt == FCW'(RD_LATENCY - 2));
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  w_rnext = w_empty ? R_IDLE : R_READ;
      R_READ:  w_rnext = (bus.rd_ce_i && (&r_raddr)) ? R_FLUSH : R_READ;
      default: w_rnext = w_free ? R_IDLE : R_FLUSH;
    endcase
  end
  always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
    if (!memclk_rstn_i) begin
      r_wstate <= W_IDLE;
      r_writing <= 1'b0;
      r_waddr <= '0;
      r_drop <= '0;
    end else begin
      r_wstate <= w_wnext;
      r_writing <= w_wnext == W_WRITE;
      if (r_wstate == W_ARM && bus.memclk_phase_i) r_waddr <= '0;
      else if (r_wstate == W_WRITE && bus.memclk_phase_i && !(&r_waddr)) r_waddr <= r_waddr + 1'b1;
      if (w_drop && !(&r_drop)) r_drop <= r_drop + 1'b1;
    end
  end
  always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
    if (!memclk_rstn_i) begin
      r_rstate <= R_IDLE;
      r_dat <= 1'b0;
      r_rd_last <= 1'b0;
      r_rbuf <= '0;
      r_raddr <= '0;
      r_fcnt <= '0;
    end else begin
      r_rstate <= w_rnext;
      r_dat <= w_rnext == R_READ;
      r_rd_last <= w_free;
      r_fcnt <= (r_rstate == R_FLUSH) ? r_fcnt + 1'b1 : '0;
      if (r_rstate == R_IDLE && !w_empty) begin
        r_rbuf <= w_rd_ptr;
        r_raddr <= '0;
      end else if (r_rstate == R_READ && bus.rd_ce_i && !(&r_raddr)) r_raddr <= r_raddr + 1'b1;
    end
  end
  assign bus.write_buffer_o = w_wr_ptr;
  assign bus.write_addr_o = r_waddr;
  assign bus.writing_o = r_writing;
  assign bus.dat_readout_o = r_dat;
  assign bus.read_buffer_o = r_rbuf;
  assign bus.read_addr_o = r_raddr;
  assign bus.rd_last_o = r_rd_last;
  assign bus.occupancy_o = w_occ;
  assign bus.full_o = w_full;
  assign bus.drop_count_o = r_drop;
endmodule

// File: tb/tb_uram_event_buffer_sched.sv
// tb_uram_event_buffer_sched: directed self-checking bench for the event buffer scheduler
module tb_uram_event_buffer_sched;
  logic clk, rstn, ph_prev;
  int n_tests, n_fail, cyc;
  uram_event_buffer_sched_if #(.NBUF_BITS(3), .ADDR_BITS(7), .DROP_CNT_BITS(16)) bus();
  uram_event_buffer_sched_if #(.NBUF_BITS(3), .ADDR_BITS(7), .DROP_CNT_BITS(2)) bus2();
  uram_event_buffer_sched #(.NBUF_BITS(3), .ADDR_BITS(7), .RD_LATENCY(4), .DROP_CNT_BITS(16)) dut (
    .memclk_i(clk), .memclk_rstn_i(rstn), .bus(bus)
  );
  uram_event_buffer_sched #(.NBUF_BITS(3), .ADDR_BITS(7), .RD_LATENCY(4), .DROP_CNT_BITS(2)) dut2 (
    .memclk_i(clk), .memclk_rstn_i(rstn), .bus(bus2)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    ph_prev = bus.memclk_phase_i;
    cyc++;
    bus.memclk_phase_i = (cyc % 4 == 0);
    bus2.memclk_phase_i = bus.memclk_phase_i;
  endtask
  task automatic pulse_trig();
    bus.trig_i = 1'b1;
    step();
    bus.trig_i = 1'b0;
  endtask
  task automatic wait_writing(input logic lvl, input int budget);
    for (int k = 0; k < budget && bus.writing_o !== lvl; k++) step();
  endtask
  task automatic wait_dat(input int budget);
    for (int k = 0; k < budget && bus.dat_readout_o !== 1'b1; k++) step();
  endtask
  initial begin
    int wlen, rlen, bad, lat, j, en, nl;
    n_tests = 0; n_fail = 0; cyc = 0; ph_prev = 1'b0;
    rstn = 1'b0;
    bus.memclk_phase_i = 1'b0; bus.trig_i = 1'b0; bus.rd_ce_i = 1'b1;
    bus2.memclk_phase_i = 1'b0; bus2.trig_i = 1'b0; bus2.rd_ce_i = 1'b1;
    repeat (3) step();
    check("rst_writing", bus.writing_o, 0);
    check("rst_waddr", bus.write_addr_o, 0);
    check("rst_wbuf", bus.write_buffer_o, 0);
    check("rst_occ", bus.occupancy_o, 0);
    check("rst_full", bus.full_o, 0);
    check("rst_drop", bus.drop_count_o, 0);
    check("rst_dat", bus.dat_readout_o, 0);
    check("rst_rdlast", bus.rd_last_o, 0);
    check("rst_drop2", bus2.drop_count_o, 0);
    rstn = 1'b1;
    repeat (5) step();
    pulse_trig();
    wait_writing(1'b1, 12);
    check("w_rise", bus.writing_o, 1);
    check("w_rise_after_phase", ph_prev, 1);
    check("w_addr0", bus.write_addr_o, 0);
    wlen = 0; bad = 0;
    while (bus.writing_o === 1'b1 && wlen < 600) begin
      if (bus.write_addr_o !== 7'(wlen / 4)) bad++;
      step();
      wlen++;
    end
    check("w_len", wlen, 512);
    check("w_addr_ramp_errs", bad, 0);
    check("commit_occ", bus.occupancy_o, 1);
    check("commit_wbuf", bus.write_buffer_o, 1);
    wait_dat(8);
    check("rd_start", bus.dat_readout_o, 1);
    check("rd_buf0", bus.read_buffer_o, 0);
    check("rd_addr0", bus.read_addr_o, 0);
    rlen = 0;
    while (bus.dat_readout_o === 1'b1 && rlen < 1000) begin step(); rlen++; end
    check("rd_len", rlen, 128);
    check("rd_addr_last", bus.read_addr_o, 127);
    lat = 1;
    for (int k = 0; k < 10 && bus.rd_last_o !== 1'b1; k++) begin step(); lat++; end
    check("rd_last_latency", lat, 4);
    check("rd_last_occ", bus.occupancy_o, 0);
    step();
    check("rd_last_pulse", bus.rd_last_o, 0);
    bus.rd_ce_i = 1'b0;
    pulse_trig();
    wait_writing(1'b1, 12);
    check("w2_rise", bus.writing_o, 1);
    wlen = 0;
    repeat (100) begin step(); wlen++; end
    bus.trig_i = 1'b1; step(); wlen++; bus.trig_i = 1'b0;
    check("drop_in_write", bus.drop_count_o, 1);
    while (bus.writing_o === 1'b1 && wlen < 600) begin step(); wlen++; end
    check("w2_len", wlen, 512);
    wait_dat(8);
    check("rd3_buf", bus.read_buffer_o, 1);
    j = 0; en = 0; bad = 0;
    while (bus.dat_readout_o === 1'b1 && j < 1200) begin
      if (bus.read_addr_o !== 7'(en)) bad++;
      bus.rd_ce_i = (j % 3 == 2);
      step();
      if (bus.rd_ce_i) en++;
      j++;
    end
    check("rd3_len", j, 384);
    check("rd3_addr_errs", bad, 0);
    bus.rd_ce_i = 1'b1;
    for (int k = 0; k < 10 && bus.rd_last_o !== 1'b1; k++) step();
    check("rd3_last", bus.rd_last_o, 1);
    check("rd3_free", bus.occupancy_o, 0);
    pulse_trig();
    wait_writing(1'b1, 12);
    for (int k = 0; k < 400 && bus.write_addr_o !== 7'd50; k++) step();
    check("w_at50", bus.write_addr_o, 50);
    #2 rstn = 1'b0;
    #1;
    check("arst_writing", bus.writing_o, 0);
    check("arst_waddr", bus.write_addr_o, 0);
    check("arst_wbuf", bus.write_buffer_o, 0);
    check("arst_rbuf", bus.read_buffer_o, 0);
    check("arst_drop", bus.drop_count_o, 0);
    check("arst_occ", bus.occupancy_o, 0);
    repeat (2) step();
    rstn = 1'b1;
    repeat (20) step();
    check("arst_no_commit", bus.occupancy_o, 0);
    check("arst_no_read", bus.dat_readout_o, 0);
    check("arst_idle", bus.writing_o, 0);
    bus.rd_ce_i = 1'b0;
    bad = 0; nl = 0;
    for (int i = 0; i < 8; i++) begin
      pulse_trig();
      wait_writing(1'b1, 20);
      wait_writing(1'b0, 600);
      if (bus.write_buffer_o !== 3'((i + 1) % 8)) bad++;
      if (bus.occupancy_o !== 4'(i + 1)) nl++;
    end
    check("fill_wbuf_errs", bad, 0);
    check("fill_occ_errs", nl, 0);
    check("fill_occ", bus.occupancy_o, 8);
    check("fill_full", bus.full_o, 1);
    check("fill_wbuf_wrap", bus.write_buffer_o, 0);
    pulse_trig();
    check("full_drop", bus.drop_count_o, 1);
    repeat (10) step();
    check("full_no_write", bus.writing_o, 0);
    bus.rd_ce_i = 1'b1;
    nl = 0;
    for (int k = 0; k < 2000 && bus.occupancy_o !== 4'd0; k++) begin
      step();
      if (bus.rd_last_o === 1'b1) nl++;
    end
    check("drain_occ", bus.occupancy_o, 0);
    check("drain_cnt", nl, 8);
    check("drain_rbuf", bus.read_buffer_o, 7);
    check("drain_full", bus.full_o, 0);
    bus.rd_ce_i = 1'b0;
    pulse_trig();
    wait_writing(1'b1, 12);
    wait_writing(1'b0, 600);
    check("wrap_wbuf", bus.write_buffer_o, 1);
    wait_dat(8);
    check("wrap_rbuf", bus.read_buffer_o, 0);
    pulse_trig();
    bus.rd_ce_i = 1'b1;
    repeat (127) step();
    bus.rd_ce_i = 1'b0;
    check("hold_addr127", bus.read_addr_o, 127);
    check("hold_dat", bus.dat_readout_o, 1);
    for (int k = 0; k < 700 && !(bus.writing_o === 1'b1 && bus.write_addr_o === 7'd127 && (cyc + 3) % 4 == 0); k++) step();
    check("align_found", bus.writing_o === 1'b1 && bus.write_addr_o === 7'd127, 1);
    check("pre_same_occ", bus.occupancy_o, 1);
    bus.rd_ce_i = 1'b1;
    step();
    bus.rd_ce_i = 1'b0;
    repeat (3) step();
    check("same_rd_last", bus.rd_last_o, 1);
    check("same_commit", bus.writing_o, 0);
    check("same_occ", bus.occupancy_o, 1);
    check("same_wbuf", bus.write_buffer_o, 2);
    bus.rd_ce_i = 1'b1;
    for (int k = 0; k < 400 && bus.occupancy_o !== 4'd0; k++) step();
    check("final_drain", bus.occupancy_o, 0);
    check("final_rbuf", bus.read_buffer_o, 1);
    bus2.trig_i = 1'b1; step(); bus2.trig_i = 1'b0;
    check("sat_accept", bus2.drop_count_o, 0);
    for (int m = 1; m <= 4; m++) begin
      step();
      bus2.trig_i = 1'b1; step(); bus2.trig_i = 1'b0;
      check("sat_drop", bus2.drop_count_o, (m < 3) ? m : 3);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uram_event_buffer_sched.md
Name: uram_event_buffer_sched

Overview:
- Sequences the event buffer ring that sits behind the URAM sample pipeline.
- Allocates one of 2^NBUF_BITS event buffers per trigger and drives the global write address and write-enable, both phase-locked to memclk_phase_i.
- Queues completed buffers and runs a throttled readout of each one, then frees the buffer.
- All logic runs in the memclk domain and feeds the per-channel write/read logic directly.

Parameters:
- NBUF_BITS, 3: log2 number of event buffers (8).
- ADDR_BITS, 7: log2 phase-cycles per event (128 write addresses per buffer).
- RD_LATENCY, 4: cycles from the last read address to read data exiting the buffer RAM.
- DROP_CNT_BITS, 16: width of the dropped-trigger counter.

Ports:
- memclk_i  in  1  memory clock; the only clock.
- memclk_rstn_i  in  1  reset, asynchronous assert, active-low.
- memclk_phase_i  in  1  one-cycle pulse every 4 memclk; marks phase 0.
- trig_i  in  1  trigger request, one-cycle pulse.
- write_buffer_o  out  NBUF_BITS  buffer currently being written.
- write_addr_o  out  ADDR_BITS  global write address.
- writing_o  out  1  write window active.
- dat_readout_o  out  1  readout-begin flag to the event buffer.
- read_buffer_o  out  NBUF_BITS  buffer being read.
- read_addr_o  out  ADDR_BITS  read address.
- rd_ce_i  in  1  read-side advance enable (backpressure).
- rd_last_o  out  1  one-cycle pulse when the final read word exits, RD_LATENCY after the last address.
- occupancy_o  out  NBUF_BITS+1  committed, not-yet-freed buffers.
- full_o  out  1  occupancy_o equals 2^NBUF_BITS.
- drop_count_o  out  DROP_CNT_BITS  saturating count of rejected triggers.

Behaviour:
- Reset: every output is 0; both FSMs go idle; the write and read pointers go to 0. Reset asserted mid-operation aborts all activity immediately; no partial buffer is committed.

Write FSM (W_IDLE, W_ARM, W_WRITE):
- W_IDLE: on trig_i with full_o=0 and the read side not holding the write-pointer buffer → W_ARM. A trig_i with full_o=1 increments drop_count_o (saturating at all-ones).
- W_ARM: waits for memclk_phase_i=1. On that cycle → W_WRITE; writing_o=1 and write_addr_o=0 appear on the next edge.
- W_WRITE: write_addr_o increments on every memclk_phase_i=1 cycle.
  - On memclk_phase_i=1 with write_addr_o = 2^ADDR_BITS-1: writing_o=0 on the next edge, the buffer is committed (occupancy +1), write_buffer_o increments modulo 2^NBUF_BITS, → W_IDLE.
  - write_addr_o holds its value outside W_WRITE.
- trig_i in W_ARM or W_WRITE: ignored, and increments drop_count_o.
- A write window is exactly 2^ADDR_BITS × 4 cycles long (512 at defaults).

Read FSM (R_IDLE, R_READ, R_FLUSH):
- R_IDLE: when occupancy_o>0 → R_READ. Latch read_buffer_o = read pointer; read_addr_o=0; dat_readout_o=1 for the whole of R_READ.
- R_READ: read_addr_o increments on each rd_ce_i=1 cycle.
  - On rd_ce_i=1 with read_addr_o = max → R_FLUSH; dat_readout_o=0.
- R_FLUSH: counts RD_LATENCY cycles, then pulses rd_last_o. On the same edge the buffer is freed (occupancy −1) and the read pointer advances modulo 2^NBUF_BITS → R_IDLE.

Boundary conditions:
- Commit and free on the same cycle: occupancy unchanged.
- Both pointers wrap modulo 2^NBUF_BITS. Ring order is strict FIFO; no buffer is reallocated before it is freed.
- occupancy_o never exceeds 2^NBUF_BITS and never underflows; an underflow is an assertion failure in simulation.
- rd_ce_i is ignored outside R_READ.

Decomposition:
- Package uram_sched_pkg:
  - write FSM state enum;
  - read FSM state enum;
  - NBUF_BITS and ADDR_BITS defaults;
  - localparam EVENT_CYCLES = 4 << ADDR_BITS.
- One natural sub-module, uram_sched_ring: a pointer/occupancy tracker with commit/free inputs and outputs wr_ptr, rd_ptr, occupancy, full, empty. The two FSMs and the drop counter stay in the top module.

Test Plan:
- Single trigger at reset idle, rd_ce_i tied 1:
  - writing_o rises 1 cycle after the next phase pulse and lasts 512 cycles; write_addr_o steps 0..127, one step per 4 cycles.
  - Commit then gives occupancy_o=1, write_buffer_o=1; readout runs 128 cycles.
  - rd_last_o fires 4 cycles after read_addr_o=127; occupancy_o returns to 0.
- Nine triggers, rd_ce_i=0 throughout:
  - Eight buffers committed (0..7); full_o=1; the ninth trigger gives drop_count_o=1.
- Trigger during W_WRITE: drop_count_o increments, and the write window length is unchanged.
- rd_ce_i toggled 1-of-3 cycles: read_addr_o advances only on enabled cycles, and readout length is 384 cycles.
- Commit and rd_last_o forced onto the same cycle: occupancy_o unchanged.
- Pointer wrap: write_buffer_o and read_buffer_o wrap 7→0 after 9 events.
- memclk_rstn_i asserted mid-W_WRITE at addr 50: all outputs 0 asynchronously, and the uncommitted buffer is discarded.
- drop_count_o saturation with DROP_CNT_BITS=2: the count holds at 3.
